// File: rtl/nibble_pkg.sv
// Shared constants and FSM state type for the nibble scatter block.
package nibble_pkg;
    localparam int NIBBLE_W   = 4;
    localparam int NUM_SLOTS  = 8;
    localparam int SLOT_IDX_W = 3;
    localparam int DATA_W     = NIBBLE_W * NUM_SLOTS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/nibble_write_dec.sv
// 3-to-8 one-hot slot decoder; all enables low when en is low.
module nibble_write_dec
    import nibble_pkg::*;
(
    input  logic                  en,
    input  logic [SLOT_IDX_W-1:0] idx,
    output logic [NUM_SLOTS-1:0]  we
);
    always_comb begin
        we = '0;
        if (en) we[idx] = 1'b1;
    end
endmodule

// File: rtl/nibble_scatter.sv
// Splits a byte into two nibbles and writes them into slots M then m of a 32-bit register.
// Optional readback outputs (result, match) when NIBBLE_SCATTER_READBACK_EN is defined.
module nibble_scatter
    import nibble_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_DATA = 32'h0000_0000
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic [5:0]        Mm,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
`ifdef NIBBLE_SCATTER_READBACK_EN
    ,
    output logic [7:0]        result,
    output logic              match
`endif
);
    state_t                state;
    logic [7:0]            hold_byte;
    logic [SLOT_IDX_W-1:0] hold_hi_idx, hold_lo_idx;
    logic                  wr_en;
    logic [SLOT_IDX_W-1:0] wr_idx;
    logic [NIBBLE_W-1:0]   wr_nib;
    logic [NUM_SLOTS-1:0]  we;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // A single decoder serves both write phases; the phase selects index and nibble.
    assign wr_en  = (state == WR_HI) || (state == WR_LO);
    assign wr_idx = (state == WR_HI) ? hold_hi_idx : hold_lo_idx;
    assign wr_nib = (state == WR_HI) ? hold_byte[7:4] : hold_byte[3:0];

    nibble_write_dec u_dec (
        .en  (wr_en),
        .idx (wr_idx),
        .we  (we)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state       <= IDLE;
            hold_byte   <= '0;
            hold_hi_idx <= '0;
            hold_lo_idx <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    hold_byte   <= in_byte;
                    hold_hi_idx <= Mm[5:3];
                    hold_lo_idx <= Mm[2:0];
                    state       <= WR_HI;
                end
                WR_HI:   state <= WR_LO;
                WR_LO:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            data <= INIT_DATA;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++)
                if (we[k]) data[k*NIBBLE_W +: NIBBLE_W] <= wr_nib;
        end
    end

`ifdef NIBBLE_SCATTER_READBACK_EN
    logic [7:0] readback;
    assign readback = {data[{hold_hi_idx, 2'b00} +: NIBBLE_W],
                       data[{hold_lo_idx, 2'b00} +: NIBBLE_W]};

    always_ff @(posedge sysclk) begin
        if (reset) begin
            result <= '0;
            match  <= 1'b0;
        end else if (state == DONE) begin
            result <= readback;
            match  <= (readback == hold_byte);
        end
    end
`endif
endmodule

// File: tb/tb_nibble_scatter.sv
// Directed-vector bench for nibble_scatter (INIT_DATA = 32'h7654_3210).
module tb_nibble_scatter;
    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = 8'h00;
    logic [5:0]  Mm = 6'b0;
    logic [31:0] data;
    logic        busy, done;
`ifdef NIBBLE_SCATTER_READBACK_EN
    logic [7:0]  result;
    logic        match;
`endif

    int vectors = 0;
    int errors  = 0;

    localparam logic [31:0] INIT = 32'h7654_3210;

    nibble_scatter #(.INIT_DATA(INIT)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_byte  (in_byte),
        .Mm       (Mm),
        .data     (data),
        .busy     (busy),
        .done     (done)
`ifdef NIBBLE_SCATTER_READBACK_EN
        ,
        .result   (result),
        .match    (match)
`endif
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++; if (data !== INIT) begin errors++; $display("FAIL reset_data got=%h exp=%h", data, INIT); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef NIBBLE_SCATTER_READBACK_EN
        vectors++; if ({result, match} !== 9'h0) begin errors++; $display("FAIL reset_rb got=%h/%b exp=00/0", result, match); end
`endif
    endtask

    task automatic test_distinct();
        in_valid = 1'b1; in_byte = 8'hAB; Mm = 6'b111_000;
        tick();
        in_valid = 1'b0; in_byte = 8'h00; Mm = 6'b0;
        vectors++; if (data !== INIT) begin errors++; $display("FAIL dist_k data=%h exp=%h", data, INIT); end
        vectors++; if ({busy, in_ready, done} !== 3'b100) begin errors++; $display("FAIL dist_k_ctl got=%b exp=100", {busy, in_ready, done}); end
        tick();
        vectors++; if (data !== 32'hA654_3210) begin errors++; $display("FAIL dist_hi data=%h exp=a6543210", data); end
        vectors++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL dist_hi_ctl got=%b exp=10", {busy, done}); end
        tick();
        vectors++; if (data !== 32'hA654_321B) begin errors++; $display("FAIL dist_lo data=%h exp=a654321b", data); end
        vectors++; if ({busy, done} !== 2'b11) begin errors++; $display("FAIL dist_done got=%b exp=11", {busy, done}); end
        tick();
        vectors++; if ({busy, in_ready, done} !== 3'b010) begin errors++; $display("FAIL dist_idle got=%b exp=010", {busy, in_ready, done}); end
    endtask

    task automatic test_equal();
        in_valid = 1'b1; in_byte = 8'hC5; Mm = 6'b101_101;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++; if (data !== 32'hA6C4_321B) begin errors++; $display("FAIL eq_hi data=%h exp=a6c4321b", data); end
        tick();
        vectors++; if (data !== 32'hA654_321B) begin errors++; $display("FAIL eq_lo data=%h exp=a654321b", data); end
        tick();
`ifdef NIBBLE_SCATTER_READBACK_EN
        vectors++; if ({result, match} !== {8'h55, 1'b0}) begin errors++; $display("FAIL eq_rb got=%h/%b exp=55/0", result, match); end
`endif
    endtask

    task automatic test_busy_ignore();
        int accepts = 0;
        in_valid = 1'b1; in_byte = 8'h12; Mm = 6'b000_001;
        tick();
        for (int i = 0; i < 3; i++) begin
            in_byte = 8'hF0 + 8'(i); Mm = 6'b111_110 - 6'(i);
            if (in_ready && in_valid) accepts++;
            tick();
        end
        in_valid = 1'b0;
        vectors++; if (accepts !== 0) begin errors++; $display("FAIL busy_accepts got=%0d exp=0", accepts); end
        vectors++; if (data !== 32'hA654_3221) begin errors++; $display("FAIL busy_data data=%h exp=a6543221", data); end
        vectors++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL busy_idle got=%b exp=01", {busy, in_ready}); end
        tick();
        vectors++; if (data !== 32'hA654_3221 || busy !== 1'b0) begin errors++; $display("FAIL busy_hold data=%h busy=%b exp=a6543221/0", data, busy); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_byte = 8'h9F; Mm = 6'b011_100;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++; if (data !== 32'hA654_9221) begin errors++; $display("FAIL mid_hi data=%h exp=a6549221", data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (data !== INIT) begin errors++; $display("FAIL mid_data got=%h exp=%h", data, INIT); end
        vectors++; if ({busy, in_ready, done} !== 3'b010) begin errors++; $display("FAIL mid_ctl got=%b exp=010", {busy, in_ready, done}); end
        tick();
        vectors++; if ({done, data} !== {1'b0, INIT}) begin errors++; $display("FAIL mid_after done=%b data=%h exp=0/%h", done, data, INIT); end
    endtask

    task automatic test_reset_priority();
        reset = 1'b1; in_valid = 1'b1; in_byte = 8'h77; Mm = 6'b001_010;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        vectors++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL prio_ctl got=%b exp=01", {busy, in_ready}); end
        tick();
        vectors++; if (data !== INIT) begin errors++; $display("FAIL prio_data got=%h exp=%h", data, INIT); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_byte = 8'h81; Mm = 6'b110_010;
        tick();
        in_byte = 8'hED; Mm = 6'b000_111;
        tick();
        tick();
        vectors++; if (data !== 32'h7854_3110) begin errors++; $display("FAIL b2b_first data=%h exp=78543110", data); end
        tick();
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        tick();
        tick();
        vectors++; if ({done, data} !== {1'b1, 32'hD854_311E}) begin errors++; $display("FAIL b2b_second done=%b data=%h exp=1/d854311e", done, data); end
        tick();
    endtask

`ifdef NIBBLE_SCATTER_READBACK_EN
    task automatic test_readback();
        in_valid = 1'b1; in_byte = 8'h3E; Mm = 6'b010_101;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        vectors++; if ({result, match} !== {8'h3E, 1'b1}) begin errors++; $display("FAIL rb got=%h/%b exp=3e/1", result, match); end
    endtask
`endif

    initial begin
        test_reset();
        test_distinct();
        test_equal();
        test_busy_ignore();
        test_reset_mid();
        test_reset_priority();
        test_back_to_back();
`ifdef NIBBLE_SCATTER_READBACK_EN
        test_readback();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
